// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - 256-bit cache line to 4x64-bit burst memory adapter
//
// Accepts one cache-line read or write at a time and turns it into a
// four-beat burst on the memory side. A write takes priority when both
// requests are raised together. Each burst beat is counted on a cycle with
// bmem_resp high. Cycles without bmem_resp hold the beat. After the fourth
// beat, line_resp pulses for one cycle.
//
// Optional feature: define CACHELINE_ADAPTER_PERF_EN to build the completed
// burst counters. Without it, perf_rd_bursts and perf_wr_bursts are tied to 0.
//
// Ports:
//   clk            - sole clock, rising edge
//   rst            - synchronous active-low reset
//   line_address   - cache-line address, bits [4:0] ignored
//   line_read      - line read request, held until line_resp
//   line_write     - line write request, held until line_resp
//   line_wdata     - line to write, beat k = bits [64k+63:64k]
//   line_rdata     - assembled read line, stable from DONE until next read
//   line_resp      - one-cycle completion pulse
//   bmem_address   - burst base address (line aligned), 0 when not bursting
//   bmem_read      - high for the whole read burst
//   bmem_write     - high for the whole write burst
//   bmem_wdata     - current write beat
//   bmem_rdata     - current read beat
//   bmem_resp      - beat accepted/returned this cycle
//   perf_rd_bursts - completed read bursts (wraps)
//   perf_wr_bursts - completed write bursts (wraps)

module cacheline_adapter (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  line_address,
  input  logic         line_read,
  input  logic         line_write,
  input  logic [255:0] line_wdata,
  output logic [255:0] line_rdata,
  output logic         line_resp,
  output logic [31:0]  bmem_address,
  output logic         bmem_read,
  output logic         bmem_write,
  output logic [63:0]  bmem_wdata,
  input  logic [63:0]  bmem_rdata,
  input  logic         bmem_resp,
  output logic [31:0]  perf_rd_bursts,
  output logic [31:0]  perf_wr_bursts
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     beat_q;
  logic [26:0]    addr_q;
  logic [255:0]   wdata_q;
  logic           last_beat;

  // The offset bits inside a line have no meaning here.
  logic           unused_addr_bits;
  assign unused_addr_bits = ^line_address[4:0];

  assign last_beat = bmem_resp && (beat_q == 2'd3);

  // Next state and outputs
  always_comb begin
    state_d      = state_q;
    bmem_read    = 1'b0;
    bmem_write   = 1'b0;
    bmem_address = 32'd0;
    line_resp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_write) begin
          state_d = WRITE;
        end else if (line_read) begin
          state_d = READ;
        end
      end
      READ: begin
        bmem_read    = 1'b1;
        bmem_address = {addr_q, 5'b0};
        if (last_beat) begin
          state_d = DONE;
        end
      end
      WRITE: begin
        bmem_write   = 1'b1;
        bmem_address = {addr_q, 5'b0};
        if (last_beat) begin
          state_d = DONE;
        end
      end
      DONE: begin
        line_resp = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The write beat follows the counter combinationally, so a gap cycle
  // keeps presenting the same beat until memory takes it.
  assign bmem_wdata = wdata_q[{beat_q, 6'b0} +: 64];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_q     <= 2'd0;
      addr_q     <= 27'd0;
      wdata_q    <= 256'd0;
      line_rdata <= 256'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          // Capture only on acceptance; these stay frozen until back in IDLE.
          if (line_write || line_read) begin
            beat_q <= 2'd0;
            addr_q <= line_address[31:5];
          end
          if (line_write) begin
            wdata_q <= line_wdata;
          end
        end
        READ: begin
          if (bmem_resp) begin
            line_rdata[{beat_q, 6'b0} +: 64] <= bmem_rdata;
            beat_q <= beat_q + 2'd1;
          end
        end
        WRITE: begin
          if (bmem_resp) begin
            beat_q <= beat_q + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef CACHELINE_ADAPTER_PERF_EN
  logic [31:0] rd_bursts_q;
  logic [31:0] wr_bursts_q;

  // A burst counts when it completes, that is, when it enters DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_bursts_q <= 32'd0;
      wr_bursts_q <= 32'd0;
    end else begin
      if (state_q == READ && last_beat) begin
        rd_bursts_q <= rd_bursts_q + 32'd1;
      end
      if (state_q == WRITE && last_beat) begin
        wr_bursts_q <= wr_bursts_q + 32'd1;
      end
    end
  end

  assign perf_rd_bursts = rd_bursts_q;
  assign perf_wr_bursts = wr_bursts_q;
`else
  assign perf_rd_bursts = 32'd0;
  assign perf_wr_bursts = 32'd0;
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb/tb_cacheline_adapter.sv - randomized self-checking bench for cacheline_adapter

module tb_cacheline_adapter;

  logic         clk;
  logic         rst;
  logic [31:0]  line_address;
  logic         line_read;
  logic         line_write;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [31:0]  bmem_address;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic [63:0]  bmem_rdata;
  logic         bmem_resp;
  logic [31:0]  perf_rd_bursts;
  logic [31:0]  perf_wr_bursts;

  int checks;
  int errors;

  // Expected state kept by the bench
  logic [255:0] exp_rdata;
  int           n_rd;
  int           n_wr;

  cacheline_adapter dut (
    .clk            (clk),
    .rst            (rst),
    .line_address   (line_address),
    .line_read      (line_read),
    .line_write     (line_write),
    .line_wdata     (line_wdata),
    .line_rdata     (line_rdata),
    .line_resp      (line_resp),
    .bmem_address   (bmem_address),
    .bmem_read      (bmem_read),
    .bmem_write     (bmem_write),
    .bmem_wdata     (bmem_wdata),
    .bmem_rdata     (bmem_rdata),
    .bmem_resp      (bmem_resp),
    .perf_rd_bursts (perf_rd_bursts),
    .perf_wr_bursts (perf_wr_bursts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " bmem_read"}, bmem_read, 1'b0);
    check({tag, " bmem_write"}, bmem_write, 1'b0);
    check({tag, " bmem_address"}, bmem_address, 32'd0);
    check({tag, " line_resp"}, line_resp, 1'b0);
  endtask

  // One line transaction. Call at a negedge with the DUT idle.
  // pat/patlen give a fixed bmem_resp pattern (LSB first), patlen=0 means random gaps.
  task automatic do_txn(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [255:0] wd, input logic [255:0] beats,
                        input logic [31:0] pat, input int patlen, input bit drop_ok);
    int           nbeat;
    int           cyc;
    bit           resp;
    bit           is_wr;
    logic [31:0]  exp_addr;

    is_wr    = wr;
    exp_addr = {addr[31:5], 5'b0};
    line_address = addr;
    line_wdata   = wd;
    line_write   = wr;
    line_read    = rd;
    bmem_resp    = 1'b0;
    nbeat = 0;
    cyc   = 0;
    @(negedge clk);
    while (nbeat < 4 && cyc < 200) begin
      check("burst bmem_read", bmem_read, !is_wr);
      check("burst bmem_write", bmem_write, is_wr);
      check("burst bmem_address", bmem_address, exp_addr);
      check("burst line_resp", line_resp, 1'b0);
      if (is_wr) check("bmem_wdata", bmem_wdata, wd[nbeat*64 +: 64]);
      if (patlen > 0) resp = (cyc < patlen) ? pat[cyc] : 1'b1;
      else            resp = ($urandom_range(0, 2) != 0);
      bmem_resp  = resp;
      bmem_rdata = resp ? beats[nbeat*64 +: 64] : 64'(rand256());
      if (resp) nbeat++;
      // Captured request must not follow input changes mid-burst.
      line_address = $urandom;
      line_wdata   = rand256();
      if (drop_ok && $urandom_range(0, 3) == 0) begin
        line_read  = 1'b0;
        line_write = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    check("burst beats done", nbeat, 4);
    // DUT now in DONE; bmem_resp may still be high and must be ignored.
    if (is_wr) n_wr++;
    else begin
      n_rd++;
      exp_rdata = beats;
    end
    check("done line_resp", line_resp, 1'b1);
    check("done bmem_read", bmem_read, 1'b0);
    check("done bmem_write", bmem_write, 1'b0);
    check("done bmem_address", bmem_address, 32'd0);
    check("done line_rdata", line_rdata, exp_rdata);
    bmem_resp  = 1'b0;
    line_read  = 1'b0;
    line_write = 1'b0;
    @(negedge clk);
    check_idle("after");
    check("after line_rdata", line_rdata, exp_rdata);
  endtask

  logic [255:0] b;
  logic [255:0] w;
  int           kind;
  logic [31:0]  exp_rd_perf;
  logic [31:0]  exp_wr_perf;

  initial begin
    checks = 0;
    errors = 0;
    n_rd = 0;
    n_wr = 0;
    exp_rdata = '0;
    rst = 1'b0;
    line_address = '0;
    line_read = 1'b0;
    line_write = 1'b0;
    line_wdata = '0;
    bmem_rdata = '0;
    bmem_resp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle("reset");
    check("reset line_rdata", line_rdata, 256'd0);
    check("reset perf_rd", perf_rd_bursts, 32'd0);
    check("reset perf_wr", perf_wr_bursts, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Stray bmem_resp in IDLE
    bmem_resp = 1'b1;
    @(negedge clk);
    check_idle("stray1");
    @(negedge clk);
    check_idle("stray2");
    bmem_resp = 1'b0;
    @(negedge clk);

    // Directed read, back-to-back beats
    b = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
         64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
    do_txn(1'b0, 1'b1, 32'h1234_5678, '0, b, 32'hFFFF_FFFF, 4, 1'b0);

    // Directed write with gapped responses 1,0,1,1,0,1
    w = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
         64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
    do_txn(1'b1, 1'b0, 32'h0000_0040, w, '0, 32'b101101, 6, 1'b0);

    // Both requests: write only
    do_txn(1'b1, 1'b1, 32'hDEAD_BEEF, rand256(), rand256(), 32'd0, 0, 1'b0);

    // Reset after two beats of a read
    line_address = 32'h0000_1000;
    line_read = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      bmem_resp  = 1'b1;
      bmem_rdata = $urandom;
      @(negedge clk);
    end
    bmem_resp = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_idle("abort");
    rst = 1'b1;
    line_read = 1'b0;
    n_rd = 0;
    n_wr = 0;
    exp_rdata = '0;
    check("abort line_rdata", line_rdata, 256'd0);
    check("abort perf_rd", perf_rd_bursts, 32'd0);
    @(negedge clk);
    check_idle("abort idle");
    do_txn(1'b0, 1'b1, 32'h0000_1000, '0, rand256(), 32'd0, 0, 1'b0);

    // Randomized traffic with random gaps and mid-burst request drops
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      do_txn(kind != 0, kind != 1, $urandom, rand256(), rand256(), 32'd0, 0, 1'b1);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

`ifdef CACHELINE_ADAPTER_PERF_EN
    exp_rd_perf = 32'(n_rd);
    exp_wr_perf = 32'(n_wr);
`else
    exp_rd_perf = 32'd0;
    exp_wr_perf = 32'd0;
`endif
    check("perf_rd_bursts", perf_rd_bursts, exp_rd_perf);
    check("perf_wr_bursts", perf_wr_bursts, exp_wr_perf);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cacheline_adapter.md
CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-low reset: low at a rising clk edge resets all state.
REQ-003 SHALL have port line_address, input, 32, cache-line request address; bits [4:0] ignored.
REQ-004 SHALL have port line_read, input, 1, line read request, held by upstream until line_resp.
REQ-005 SHALL have port line_write, input, 1, line write request, held by upstream until line_resp.
REQ-006 SHALL have port line_wdata, input, 256, line to write; beat k = bits [64k+63:64k].
REQ-007 SHALL have port line_rdata, output, 256, assembled read line.
REQ-008 SHALL have port line_resp, output, 1, one-cycle completion pulse.
REQ-009 SHALL have ports bmem_address (output, 32), bmem_read (output, 1), bmem_write (output, 1), bmem_wdata (output, 64), bmem_rdata (input, 64), bmem_resp (input, 1) to burst memory.
REQ-010 SHALL have ports perf_rd_bursts and perf_wr_bursts, output, 32 each, completed-burst counters.

Function
REQ-011 SHALL implement states IDLE, READ, WRITE, DONE.
REQ-012 In IDLE, line_write=1 SHALL capture address and line_wdata and go to WRITE; otherwise line_read=1 SHALL capture address and go to READ. Both high: write wins.
REQ-013 bmem_address SHALL equal {captured_addr[31:5], 5'b0} in READ and WRITE, and 0 in IDLE and DONE.
REQ-014 bmem_read SHALL be 1 exactly while in READ; bmem_write SHALL be 1 exactly while in WRITE.
REQ-015 A 2-bit beat counter SHALL reset to 0 on entry to READ or WRITE and increment on each cycle with bmem_resp=1; gaps without bmem_resp SHALL hold it.
REQ-016 In READ, each bmem_resp cycle SHALL store bmem_rdata into line_rdata beat slot [counter]; after beat 3, go to DONE.
REQ-017 In WRITE, bmem_wdata SHALL present captured beat [counter] combinationally; after bmem_resp on beat 3, go to DONE.
REQ-018 DONE SHALL assert line_resp for exactly one cycle, then go to IDLE; a new request SHALL NOT be accepted in DONE.
REQ-019 Minimum latency: line_resp SHALL rise the cycle after the 4th beat's bmem_resp.
REQ-020 line_rdata SHALL hold its value from DONE until the next READ overwrites it, and SHALL be valid during the line_resp cycle.
REQ-021 bmem_resp while in IDLE or DONE SHALL be ignored with no state change.
REQ-022 Deassertion of line_read/line_write mid-burst SHALL NOT abort the burst.
REQ-023 Captured address and wdata SHALL NOT change while in READ, WRITE or DONE.

Reset
REQ-024 On rst=0: state IDLE, counter 0, line_rdata 0, line_resp 0, bmem_read 0, bmem_write 0, bmem_address 0, perf counters 0.
REQ-025 Reset mid-burst SHALL abort at that edge, with bmem_read/bmem_write low the following cycle and no line_resp.

Configuration
REQ-026 Macro CACHELINE_ADAPTER_PERF_EN: when defined, perf_rd_bursts/perf_wr_bursts SHALL increment by 1 on each READ/WRITE completion (entry to DONE) and wrap at 2^32-1 to 0.
REQ-027 Without CACHELINE_ADAPTER_PERF_EN, both perf outputs SHALL be constant 0, with no counter flops.

Verification
REQ-028 Read 0x1234_5678, bmem beats 0xA0..,0xA1..,0xA2..,0xA3.. on 4 consecutive resp cycles -> bmem_address=0x1234_5660, line_resp one cycle after beat 3, line_rdata={A3,A2,A1,A0}.
REQ-029 Write 0x0000_0040 with line_wdata={D3,D2,D1,D0} and bmem_resp gapped as 1,0,1,1,0,1 -> bmem_wdata sequence D0,D1,D1,D2,D3,D3, single line_resp after the last resp.
REQ-030 line_read=1 and line_write=1 together -> WRITE burst only, bmem_read never asserted.
REQ-031 rst=0 after beat 2 of a read -> next cycle IDLE, bmem_read=0, no line_resp; a following read completes normally.
REQ-032 Stray bmem_resp in IDLE -> no state change and no line_resp.
REQ-033 With CACHELINE_ADAPTER_PERF_EN: 3 reads and 2 writes -> perf_rd_bursts=3, perf_wr_bursts=2; without the macro both remain 0.
